alu: RTL and testbench
======================

# alu

Combinational 32-bit integer ALU for the execute stage of the five-stage fixed-point pipeline. Operands come from the execute pipeline register (op1_data, op2_data, ctrl_alu_fun). The result feeds the memory-stage register and the decode-stage bypass muxes in the same cycle, so the result path has no register. A registered copy of the last result is also provided for debug and trace.

## Interface
- No parameters. Data width is fixed at 32.
- `clk`  input  1  system clock.
- `reset`  input  1  reset; one clock; reset is synchronous and active-high.
- `alu_in`  input  `Bundle::AluIn`  packed struct with these fields:
  - `op1` [31:0]: operand 1.
  - `op2` [31:0]: operand 2.
  - `fun` `Bundle::AluFun` (4 bits): operation select.
- `alu_out`  output  `Bundle::AluOut`  packed struct with these fields:
  - `data` [31:0]: combinational result.
  - `data_q` [31:0]: `data` registered on `clk`.

## Operation
`Bundle::AluFun` encoding is fixed:
- ADD=0: op1+op2, modulo 2^32, carry discarded.
- SUB=1: op1−op2, modulo 2^32.
- SLL=2: op1 << op2[4:0].
- SRL=3: logical right shift of op1 by op2[4:0], zero fill.
- SRA=4: arithmetic right shift of $signed(op1) by op2[4:0], sign fill.
- AND=5, OR=6, XOR=7: bitwise on op1 and op2.
- SLT=8: {31'b0, $signed(op1) < $signed(op2)}.
- SLTU=9: {31'b0, op1 < op2}, unsigned compare.
- COPY1=10: op1. Used for address and PC pass-through.
- COPY2=11: op2. Used for LUI.
- 12–15 (ALU_X / undefined): data = 0.

Rules:
- Shifts use only op2[4:0]; op2[31:5] is ignored.
- No overflow, carry or zero flags are produced. Branch compares are done outside this block.
- `data` is a pure function of `alu_in`, with no latches and no X propagation for defined `fun` values.

## Timing
- `data`: zero-cycle combinational latency. It must settle within the execute-stage cycle together with the bypass mux and the memory-register setup.
- `data_q`: updates on every rising `clk` edge to the `data` value before the edge. It has no enable and no stall input; pipeline stalls are handled by the surrounding registers.
- Reset: when `reset`=1 at a rising edge, `data_q` = 32'h0. This has priority over capture. `data` is unaffected by reset.
- If reset is asserted mid-operation, `data_q` reads 0 on the cycle after the reset edge. Capture resumes on the first edge with `reset`=0.
- Boundary values:
  - ADD 32'hFFFF_FFFF+1 → 0 (wraps).
  - SUB 0−1 → 32'hFFFF_FFFF.
  - SRA by 0 → op1.
  - SLL by 31 keeps only op1[0] in bit 31.
  - SLT with equal operands → 0.

## Test plan
- Arithmetic:
  - ADD 32'h7FFF_FFFF+1 → 32'h8000_0000.
  - ADD 32'hFFFF_FFFF+1 → 0.
  - SUB 5−7 → 32'hFFFF_FFFE.
- Shifts, with op1=32'h8000_00F0:
  - SLL by op2=32'h0000_0024 (amount 4) → 32'h0000_0F00.
  - SRL by 4 → 32'h0800_000F.
  - SRA by 4 → 32'hF800_000F.
- Compares:
  - SLT 32'hFFFF_FFFF vs 1 → 1.
  - SLTU 32'hFFFF_FFFF vs 1 → 0.
  - SLT 3 vs 3 → 0.
- Logic and copy, with op1=32'hF0F0_1234, op2=32'h0FF0_FFFF:
  - AND → 32'h00F0_1234.
  - OR → 32'hFFF0_FFFF.
  - XOR → 32'hFF00_EDCB.
  - COPY1 → op1.
  - COPY2 → op2.
  - fun=15 → 0.
- Register and reset:
  - Hold `reset`=1 for 2 edges → `data_q`=0.
  - Release reset with ADD 2+3 → `data_q`=5 after the next edge.
  - Assert reset again → `data_q`=0 on the following edge while `data` stays 5.
- Randomized sweep: 10k random op1/op2/fun values, all 16 codes, compared against a reference model. Both `data` (same cycle) and `data_q` (one cycle later) must match.

Source files
------------

// File: rtl/alu.sv
// Execute-stage 32-bit integer ALU: combinational result for bypass/memory stage,
// plus a registered copy of the last result for debug and trace.

package Bundle;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SRL   = 4'd3,
        ALU_SRA   = 4'd4,
        ALU_AND   = 4'd5,
        ALU_OR    = 4'd6,
        ALU_XOR   = 4'd7,
        ALU_SLT   = 4'd8,
        ALU_SLTU  = 4'd9,
        ALU_COPY1 = 4'd10,
        ALU_COPY2 = 4'd11
    } AluFun;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        AluFun       fun;
    } AluIn;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] data_q;
    } AluOut;

endpackage

module alu
    import Bundle::*;
(
    input  logic  clk,
    input  logic  reset,
    input  AluIn  alu_in,
    output AluOut alu_out
);

    logic [31:0] data_s;
    logic [31:0] data_r;
    logic [4:0]  shamt_s;

    assign shamt_s = alu_in.op2[4:0];

    // Result select; codes 12-15 fall to the default and yield zero.
    always_comb begin
        data_s = 32'h0000_0000;
        case (alu_in.fun)
            ALU_ADD:   data_s = alu_in.op1 + alu_in.op2;
            ALU_SUB:   data_s = alu_in.op1 - alu_in.op2;
            ALU_SLL:   data_s = alu_in.op1 << shamt_s;
            ALU_SRL:   data_s = alu_in.op1 >> shamt_s;
            ALU_SRA:   data_s = $unsigned($signed(alu_in.op1) >>> shamt_s);
            ALU_AND:   data_s = alu_in.op1 & alu_in.op2;
            ALU_OR:    data_s = alu_in.op1 | alu_in.op2;
            ALU_XOR:   data_s = alu_in.op1 ^ alu_in.op2;
            ALU_SLT:   data_s = {31'b0, ($signed(alu_in.op1) < $signed(alu_in.op2))};
            ALU_SLTU:  data_s = {31'b0, (alu_in.op1 < alu_in.op2)};
            ALU_COPY1: data_s = alu_in.op1;
            ALU_COPY2: data_s = alu_in.op2;
            default:   data_s = 32'h0000_0000;
        endcase
    end

    // Trace copy of the result; reset takes priority over capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_r <= 32'h0000_0000;
        end else begin
            data_r <= data_s;
        end
    end

    assign alu_out = '{data: data_s, data_q: data_r};

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan vectors, reset behaviour and a
// randomized sweep against an arithmetic reference model.

module tb_alu;
    import Bundle::*;

    logic  clk;
    logic  reset;
    AluIn  alu_in;
    AluOut alu_out;

    int tests;
    int fails;

    alu dut (
        .clk     (clk),
        .reset   (reset),
        .alu_in  (alu_in),
        .alu_out (alu_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam longint MASK32 = 64'h0000_0000_FFFF_FFFF;

    // Reference computed with plain 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f);
        longint ua, ub, sa, sb, pw, r;
        int sh;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        pw = 64'd1 << sh;
        case (f)
            4'd0:  r = (ua + ub) & MASK32;
            4'd1:  r = (ua - ub + 64'h1_0000_0000) & MASK32;
            4'd2:  r = (ua * pw) & MASK32;
            4'd3:  r = ua / pw;
            4'd4:  r = ((sa >= 0) ? (sa / pw) : ((sa - (pw - 1)) / pw)) & MASK32;
            4'd5:  r = ua & ub;
            4'd6:  r = ua | ub;
            4'd7:  r = ua ^ ub;
            4'd8:  r = (sa < sb) ? 64'd1 : 64'd0;
            4'd9:  r = (ua < ub) ? 64'd1 : 64'd0;
            4'd10: r = ua;
            4'd11: r = ub;
            default: r = 64'd0;
        endcase
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one operation, check data same cycle and data_q after the next edge.
    task automatic step(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] f, input logic [31:0] exp);
        @(negedge clk);
        alu_in = '{op1: a, op2: b, fun: AluFun'(f)};
        #1;
        check({tag, ".data"}, alu_out.data, exp);
        @(posedge clk);
        #1;
        check({tag, ".data_q"}, alu_out.data_q, exp);
    endtask

    initial begin
        logic [31:0] a, b;
        logic [3:0]  f;
        tests  = 0;
        fails  = 0;
        reset  = 1'b1;
        alu_in = '{op1: 32'h0, op2: 32'h0, fun: ALU_ADD};

        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", alu_out.data_q, 32'h0000_0000);

        @(negedge clk);
        reset  = 1'b0;
        alu_in = '{op1: 32'd2, op2: 32'd3, fun: ALU_ADD};
        #1;
        check("rel_data", alu_out.data, 32'd5);
        @(posedge clk);
        #1;
        check("rel_data_q", alu_out.data_q, 32'd5);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_again_q", alu_out.data_q, 32'h0000_0000);
        check("rst_again_data", alu_out.data, 32'd5);
        @(negedge clk);
        reset = 1'b0;

        step("add_ovf",  32'h7FFF_FFFF, 32'h0000_0001, 4'd0,  32'h8000_0000);
        step("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 4'd0,  32'h0000_0000);
        step("sub_neg",  32'd5,         32'd7,         4'd1,  32'hFFFF_FFFE);
        step("sub_wrap", 32'd0,         32'd1,         4'd1,  32'hFFFF_FFFF);
        step("sll4",     32'h8000_00F0, 32'h0000_0024, 4'd2,  32'h0000_0F00);
        step("srl4",     32'h8000_00F0, 32'h0000_0004, 4'd3,  32'h0800_000F);
        step("sra4",     32'h8000_00F0, 32'h0000_0004, 4'd4,  32'hF800_000F);
        step("sra0",     32'h8000_00F0, 32'hFFFF_FFE0, 4'd4,  32'h8000_00F0);
        step("sll31",    32'h0000_0003, 32'h0000_001F, 4'd2,  32'h8000_0000);
        step("slt_neg",  32'hFFFF_FFFF, 32'h0000_0001, 4'd8,  32'h0000_0001);
        step("sltu_big", 32'hFFFF_FFFF, 32'h0000_0001, 4'd9,  32'h0000_0000);
        step("slt_eq",   32'd3,         32'd3,         4'd8,  32'h0000_0000);
        step("and",      32'hF0F0_1234, 32'h0FF0_FFFF, 4'd5,  32'h00F0_1234);
        step("or",       32'hF0F0_1234, 32'h0FF0_FFFF, 4'd6,  32'hFFF0_FFFF);
        step("xor",      32'hF0F0_1234, 32'h0FF0_FFFF, 4'd7,  32'hFF00_EDCB);
        step("copy1",    32'hF0F0_1234, 32'h0FF0_FFFF, 4'd10, 32'hF0F0_1234);
        step("copy2",    32'hF0F0_1234, 32'h0FF0_FFFF, 4'd11, 32'h0FF0_FFFF);
        step("fun12",    32'hF0F0_1234, 32'h0FF0_FFFF, 4'd12, 32'h0000_0000);
        step("fun15",    32'hF0F0_1234, 32'h0FF0_FFFF, 4'd15, 32'h0000_0000);

        for (int i = 0; i < 10000; i++) begin
            a = $urandom;
            b = $urandom;
            if ((i % 8) == 0) b = b & 32'h0000_003F;
            if ((i % 13) == 0) a = b;
            f = 4'($urandom_range(0, 15));
            step($sformatf("rnd%0d_f%0d", i, f), a, b, f, model(a, b, f));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
